leaf_out_arbiter: RTL

- Shares one leaf_interface output port (din_leaf_user2interface / vld / ack) between NUM_REQ HLS kernel output streams inside one page.
- Uses round-robin arbitration with bounded bursts.
- Tags every beat with the source requester index, so the page wrapper can map it to a leaf port.
- Has a 2-entry output buffer that registers all signals toward leaf_interface.

---
 rtl/leaf_arb_pkg.sv | 22 ++
 rtl/leaf_arb_skid_fifo.sv | 64 ++++++
 rtl/leaf_out_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/leaf_arb_pkg.sv
// Shared types and constants for the leaf output arbiter.
package leaf_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned DEFAULT_PAYLOAD_BITS = 32;
  localparam int unsigned DEFAULT_BURST_LEN    = 16;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/leaf_arb_skid_fifo.sv
// Two-entry output buffer; the head entry drives the leaf_interface outputs directly from flops.
module leaf_arb_skid_fifo #(
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != 2'd2);
    do_pop   = pop && (count_q != 2'd0);

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one leaf_interface output port between
// NUM_REQ kernel streams; each beat is tagged with its source requester index.
module leaf_out_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
  parameter int unsigned BURST_LEN    = DEFAULT_BURST_LEN,
  parameter int unsigned REQ_ID_BITS  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_user2arb,
  input  logic [NUM_REQ-1:0]              vld_user2arb,
  output logic [NUM_REQ-1:0]              ack_arb2user,
  output logic [PAYLOAD_BITS-1:0]         dout_arb2interface,
  output logic [REQ_ID_BITS-1:0]          id_arb2interface,
  output logic                            vld_arb2interface,
  input  logic                            ack_interface2arb,
  output logic                            busy
);

  localparam int unsigned CNT_BITS   = (clog2(BURST_LEN) < 1) ? 1 : clog2(BURST_LEN);
  localparam int unsigned ENTRY_BITS = PAYLOAD_BITS + REQ_ID_BITS;
  localparam logic [CNT_BITS-1:0]    LAST_BEAT = CNT_BITS'(BURST_LEN - 1);
  localparam logic [REQ_ID_BITS-1:0] LAST_REQ  = REQ_ID_BITS'(NUM_REQ - 1);
  localparam logic [REQ_ID_BITS:0]   NUM_REQ_W = (REQ_ID_BITS + 1)'(NUM_REQ);

  arb_state_e                state_q, state_d;
  logic [REQ_ID_BITS-1:0]    rr_ptr_q, rr_ptr_d;
  logic [REQ_ID_BITS-1:0]    gnt_q, gnt_d;
  logic [CNT_BITS-1:0]       beat_cnt_q, beat_cnt_d;

  logic [REQ_ID_BITS-1:0]    pick;
  logic                      pick_valid;
  logic [REQ_ID_BITS:0]      scan_sum;
  logic [REQ_ID_BITS-1:0]    scan_id;

  logic                      gnt_vld, gnt_ack, accept;
  logic [PAYLOAD_BITS-1:0]   gnt_payload;

  logic [1:0]                buf_count;
  logic                      buf_empty;
  logic [ENTRY_BITS-1:0]     buf_head;

  // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    scan_sum   = '0;
    scan_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (REQ_ID_BITS + 1)'(i);
      if (scan_sum >= NUM_REQ_W) scan_sum = scan_sum - NUM_REQ_W;
      scan_id = REQ_ID_BITS'(scan_sum);
      if (!pick_valid && vld_user2arb[scan_id]) begin
        pick       = scan_id;
        pick_valid = 1'b1;
      end
    end
  end

  // Ack depends only on registered state and buffer occupancy.
  always_comb begin
    gnt_vld      = 1'b0;
    gnt_payload  = '0;
    ack_arb2user = '0;
    gnt_ack      = (state_q == GRANT) && (buf_count != 2'd2);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_q == REQ_ID_BITS'(i)) begin
        gnt_vld         = vld_user2arb[i];
        gnt_payload     = din_user2arb[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        ack_arb2user[i] = gnt_ack;
      end
    end
    accept = gnt_ack && gnt_vld;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d      = pick;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if ((accept && (beat_cnt_q == LAST_BEAT)) || !gnt_vld) begin
          rr_ptr_d = (gnt_q == LAST_REQ) ? '0 : gnt_q + 1'b1;
          state_d  = IDLE;
        end
        if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  leaf_arb_skid_fifo #(
    .WIDTH(ENTRY_BITS)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data ({gnt_q, gnt_payload}),
    .pop       (!buf_empty && ack_interface2arb),
    .head_data (buf_head),
    .count     (buf_count),
    .empty     (buf_empty)
  );

  assign vld_arb2interface  = !buf_empty;
  assign dout_arb2interface = buf_head[PAYLOAD_BITS-1:0];
  assign id_arb2interface   = buf_head[ENTRY_BITS-1 -: REQ_ID_BITS];
  assign busy               = (state_q == GRANT) || (buf_count != 2'd0);

  // Upstream must hold its payload while it is valid and not yet acknowledged.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold_chk
    a_payload_hold: assert property (@(posedge clk) disable iff (reset)
      (vld_user2arb[g] && !ack_arb2user[g]) |=>
        (!vld_user2arb[g] || $stable(din_user2arb[g*PAYLOAD_BITS +: PAYLOAD_BITS])));
  end

endmodule
